io_port_bridge: RTL and testbench

//   External-side counterpart of the CPU's 8-bit I/O ports (in_p0/in_p1 <-> out_p0/out_p1).
//   - Port 0 writes from the CPU are buffered in a TX FIFO and drained to an external

---
 rtl/io_port_bridge.sv | 124 ++++++++++++
 tb/tb_io_port_bridge.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/io_port_bridge.sv
// External-side bridge for the CPU's 8-bit I/O ports.
// Port 0 writes go out through a TX FIFO, and an RX mailbox feeds input port 0.
module io_port_bridge #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] cpu_out_p0,
    input  logic [DATA_W-1:0] cpu_out_p1,
    input  logic              cpu_we_p0,
    input  logic              cpu_we_p1,
    output logic [DATA_W-1:0] cpu_in_p0,
    output logic [DATA_W-1:0] cpu_in_p1,
    output logic [DATA_W-1:0] ext_tx_data,
    output logic              ext_tx_valid,
    input  logic              ext_tx_ready,
    input  logic [DATA_W-1:0] ext_rx_data,
    input  logic              ext_rx_valid,
    output logic              ext_rx_ready
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic {
        RX_EMPTY = 1'b0,
        RX_FULL  = 1'b1
    } rx_state_t;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0] mem_d [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              overflow_q, overflow_d;
    rx_state_t         rx_state_q, rx_state_d;
    logic [DATA_W-1:0] rx_data_q, rx_data_d;

    logic tx_full, tx_empty, pop, push, drop, clr_ovf, rx_ack;

    assign tx_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign tx_empty = (count_q == '0);
    assign pop      = !tx_empty && ext_tx_ready;
    // A push into a full FIFO survives only when the head leaves on the same edge.
    assign push     = cpu_we_p0 && (!tx_full || pop);
    assign drop     = cpu_we_p0 && tx_full && !pop;
    assign clr_ovf  = cpu_we_p1 && cpu_out_p1[1];
    assign rx_ack   = cpu_we_p1 && cpu_out_p1[0];

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            mem_d[wr_ptr_q] = cpu_out_p0;
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        count_d = count_q + CNT_W'(push) - CNT_W'(pop);
    end

    // A dropped push outranks a clear landing on the same edge.
    always_comb begin
        overflow_d = overflow_q;
        if (drop) begin
            overflow_d = 1'b1;
        end else if (clr_ovf) begin
            overflow_d = 1'b0;
        end
    end

    always_comb begin
        rx_state_d   = rx_state_q;
        rx_data_d    = rx_data_q;
        ext_rx_ready = 1'b0;
        unique case (rx_state_q)
            RX_EMPTY: begin
                ext_rx_ready = 1'b1;
                if (ext_rx_valid) begin
                    rx_data_d  = ext_rx_data;
                    rx_state_d = RX_FULL;
                end
            end
            RX_FULL: begin
                if (rx_ack) begin
                    rx_state_d = RX_EMPTY;
                end
            end
            default: rx_state_d = RX_EMPTY;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rx_state_q <= RX_EMPTY;
            rx_data_q  <= '0;
        end else begin
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rx_state_q <= rx_state_d;
            rx_data_q  <= rx_data_d;
        end
    end

    assign ext_tx_data  = mem_q[rd_ptr_q];
    assign ext_tx_valid = !tx_empty;
    assign cpu_in_p0    = rx_data_q;
    assign cpu_in_p1    = {{(DATA_W-4){1'b0}}, overflow_q, tx_empty, tx_full,
                           rx_state_q == RX_FULL};

endmodule

// File: tb/tb_io_port_bridge.sv
// Bench for io_port_bridge: directed scenarios then random traffic,
// checked against a queue-based model of the FIFO and mailbox.
module tb_io_port_bridge;

    localparam int W = 8;
    localparam int D = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] cpu_out_p0, cpu_out_p1;
    logic         cpu_we_p0, cpu_we_p1;
    logic [W-1:0] cpu_in_p0, cpu_in_p1;
    logic [W-1:0] ext_tx_data;
    logic         ext_tx_valid, ext_tx_ready;
    logic [W-1:0] ext_rx_data;
    logic         ext_rx_valid, ext_rx_ready;

    io_port_bridge #(.DATA_W(W), .FIFO_DEPTH(D)) dut (
        .clk          (clk),
        .reset        (reset),
        .cpu_out_p0   (cpu_out_p0),
        .cpu_out_p1   (cpu_out_p1),
        .cpu_we_p0    (cpu_we_p0),
        .cpu_we_p1    (cpu_we_p1),
        .cpu_in_p0    (cpu_in_p0),
        .cpu_in_p1    (cpu_in_p1),
        .ext_tx_data  (ext_tx_data),
        .ext_tx_valid (ext_tx_valid),
        .ext_tx_ready (ext_tx_ready),
        .ext_rx_data  (ext_rx_data),
        .ext_rx_valid (ext_rx_valid),
        .ext_rx_ready (ext_rx_ready)
    );

    always #5 clk = ~clk;

    logic [W-1:0] q [$];
    bit           m_ovf;
    bit           m_rxf;
    logic [W-1:0] m_rxd;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        logic [7:0] st;
        st = {4'b0, m_ovf, q.size() == 0, q.size() == D, m_rxf};
        chk({tag, " in_p1"}, cpu_in_p1, st);
        chk({tag, " tx_valid"}, ext_tx_valid, q.size() != 0);
        if (q.size() != 0) chk({tag, " tx_data"}, ext_tx_data, q[0]);
        chk({tag, " rx_ready"}, ext_rx_ready, !m_rxf);
        chk({tag, " in_p0"}, cpu_in_p0, m_rxd);
    endtask

    task automatic model_reset();
        q.delete();
        m_ovf = 0;
        m_rxf = 0;
        m_rxd = '0;
    endtask

    // Advance one edge, apply the model's rules to the inputs seen there.
    task automatic tick(input string tag);
        bit pop;
        @(posedge clk);
        pop = (q.size() != 0) && ext_tx_ready;
        if (cpu_we_p0 && q.size() == D && !pop) begin
            m_ovf = 1;
        end else begin
            if (cpu_we_p1 && cpu_out_p1[1]) m_ovf = 0;
            if (pop) void'(q.pop_front());
            if (cpu_we_p0) q.push_back(cpu_out_p0);
        end
        if (pop && cpu_we_p0 && q.size() > D) void'(q.pop_front());
        if (!m_rxf) begin
            if (ext_rx_valid) begin
                m_rxd = ext_rx_data;
                m_rxf = 1;
            end
        end else if (cpu_we_p1 && cpu_out_p1[0]) begin
            m_rxf = 0;
        end
        #1;
        cpu_we_p0 = 0;
        cpu_we_p1 = 0;
        check_all(tag);
    endtask

    task automatic wr0(input logic [7:0] b, input string tag);
        cpu_out_p0 = b;
        cpu_we_p0  = 1;
        tick(tag);
    endtask

    task automatic wr1(input logic [7:0] b, input string tag);
        cpu_out_p1 = b;
        cpu_we_p1  = 1;
        tick(tag);
    endtask

    initial begin
        reset        = 1;
        cpu_out_p0   = '0;
        cpu_out_p1   = '0;
        cpu_we_p0    = 0;
        cpu_we_p1    = 0;
        ext_tx_ready = 0;
        ext_rx_data  = '0;
        ext_rx_valid = 0;
        model_reset();

        #12 reset = 0;
        chk("rst in_p1", cpu_in_p1, 8'h04);
        chk("rst tx_valid", ext_tx_valid, 1'b0);
        chk("rst tx_data", ext_tx_data, 8'h00);
        chk("rst rx_ready", ext_rx_ready, 1'b1);
        chk("rst in_p0", cpu_in_p0, 8'h00);

        wr0(8'h08, "t2 w0");
        chk("t2 head", ext_tx_data, 8'h08);
        wr0(8'h0C, "t2 w1");
        wr0(8'h10, "t2 w2");
        chk("t2 status", cpu_in_p1, 8'h00);
        ext_tx_ready = 1;
        chk("t2 out0", ext_tx_data, 8'h08);
        tick("t2 d0");
        chk("t2 out1", ext_tx_data, 8'h0C);
        tick("t2 d1");
        chk("t2 out2", ext_tx_data, 8'h10);
        tick("t2 d2");
        chk("t2 empty", cpu_in_p1, 8'h04);

        ext_tx_ready = 0;
        for (int i = 0; i < 6; i++) wr0(8'hA0 + 8'(i), "t3 w");
        chk("t3 full ovf", cpu_in_p1, 8'h0A);
        wr1(8'h02, "t3 clr");
        chk("t3 clr", cpu_in_p1, 8'h02);
        ext_tx_ready = 1;
        for (int i = 0; i < 4; i++) begin
            chk("t3 drain", ext_tx_data, 8'hA0 + 8'(i));
            tick("t3 d");
        end
        chk("t3 empty", cpu_in_p1, 8'h04);

        ext_tx_ready = 0;
        for (int i = 0; i < 4; i++) wr0(8'hC0 + 8'(i), "t4 w");
        ext_tx_ready = 1;
        wr0(8'hEE, "t4 pp");
        chk("t4 full no ovf", cpu_in_p1, 8'h02);
        for (int i = 0; i < 4; i++) tick("t4 d");
        chk("t4 empty", cpu_in_p1, 8'h04);
        ext_tx_ready = 0;

        ext_rx_data  = 8'h04;
        ext_rx_valid = 1;
        tick("t5 rx0");
        chk("t5 in_p0", cpu_in_p0, 8'h04);
        chk("t5 status", cpu_in_p1, 8'h05);
        ext_rx_data = 8'h55;
        tick("t5 hold");
        chk("t5 not taken", cpu_in_p0, 8'h04);
        wr1(8'h01, "t5 ack");
        chk("t5 ack data", cpu_in_p0, 8'h04);
        chk("t5 ack ready", ext_rx_ready, 1'b1);
        tick("t5 rx1");
        chk("t5 second", cpu_in_p0, 8'h55);
        ext_rx_valid = 0;

        wr1(8'h01, "t6 ack");
        wr0(8'h31, "t6 w0");
        wr0(8'h32, "t6 w1");
        ext_rx_data  = 8'h77;
        ext_rx_valid = 1;
        tick("t6 rx");
        ext_rx_valid = 0;
        chk("t6 pre", cpu_in_p1, 8'h01);
        #2 reset = 1;
        #1;
        model_reset();
        chk("t6 async status", cpu_in_p1, 8'h04);
        chk("t6 async valid", ext_tx_valid, 1'b0);
        chk("t6 async rx_ready", ext_rx_ready, 1'b1);
        chk("t6 async in_p0", cpu_in_p0, 8'h00);
        @(negedge clk);
        reset = 0;
        check_all("t6 post");

        for (int i = 0; i < 600; i++) begin
            cpu_we_p0    = ($urandom_range(0, 99) < 55);
            cpu_out_p0   = 8'($urandom);
            cpu_we_p1    = ($urandom_range(0, 99) < 20);
            cpu_out_p1   = 8'($urandom);
            ext_tx_ready = ($urandom_range(0, 99) < 40);
            ext_rx_valid = ($urandom_range(0, 99) < 50);
            ext_rx_data  = 8'($urandom);
            tick("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
